logic_rslt_reader: RTL and testbench

Read-side controller for an operator result buffer (16 thread-indexed slots of 64-bit result plus flags, e.g. the BSET/BCLR/logic units). It sits between the CPU's two operand-fetch ports (A, B) and the operator's dual read ports. It tracks which slots hold unread results and stalls a fetch until its slot is written. It issues the buffer read, then returns the result split into the 64-bit value and the N/Z/C/V flags.

---
 rtl/logic_rslt_reader.sv | 198 +++++++++++++++++++
 tb/tb_logic_rslt_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_rslt_reader.sv
// logic_rslt_reader
// Read-side controller for an operator result buffer. It snoops the operator's
// write strobe to track which thread slots hold unread results, holds off each
// CPU operand-fetch port until its slot has been written, issues the buffer
// read, and returns the read word split into a 64-bit value and N/Z/C/V flags.
//
// Ports:
//   CLK, RESET              clock and synchronous active-high reset
//   wren, wraddrs           snoop of the operator's result-buffer writes
//   reqX, addrsX, consumeX  fetch request (held until ackX), slot, clear-on-read
//   ackX                    one-cycle grant pulse
//   rdenX, rdaddrsX         read strobe and slot towards the result buffer
//   rddataX                 buffer read word {C, V, N, Z, result}, one cycle after rdenX
//   dvalidX, resultX, flagsX  returned result, meaningful only while dvalidX is high
//   errX                    wait timeout (always 0 unless RSLT_TIMEOUT_EN)
//
// Build option: define RSLT_TIMEOUT_EN to bound the wait on an unwritten slot
// to TIMEOUT cycles; an expired wait is answered with ackX/errX and a zero result.

module logic_rslt_reader #(
    parameter int ADDRS_WIDTH = 4,
    parameter int DATA_WIDTH  = 68,
    parameter int TIMEOUT     = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   wren,
    input  logic [ADDRS_WIDTH-1:0] wraddrs,
    input  logic                   reqA,
    input  logic [ADDRS_WIDTH-1:0] addrsA,
    input  logic                   consumeA,
    output logic                   ackA,
    output logic                   rdenA,
    output logic [ADDRS_WIDTH-1:0] rdaddrsA,
    input  logic [DATA_WIDTH-1:0]  rddataA,
    output logic                   dvalidA,
    output logic [63:0]            resultA,
    output logic [3:0]             flagsA,
    output logic                   errA,
    input  logic                   reqB,
    input  logic [ADDRS_WIDTH-1:0] addrsB,
    input  logic                   consumeB,
    output logic                   ackB,
    output logic                   rdenB,
    output logic [ADDRS_WIDTH-1:0] rdaddrsB,
    input  logic [DATA_WIDTH-1:0]  rddataB,
    output logic                   dvalidB,
    output logic [63:0]            resultB,
    output logic [3:0]             flagsB,
    output logic                   errB
);

    localparam int SLOTS = 2 ** ADDRS_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
`ifdef RSLT_TIMEOUT_EN
        , ERR = 2'd2
`endif
    } portState_t;

    logic [SLOTS-1:0]       slotVld;
    logic [SLOTS-1:0]       setMask;
    logic [SLOTS-1:0]       clrMask;
    logic [1:0]             req;
    logic [1:0]             consume;
    logic [1:0]             grant;
    logic [1:0]             errPulse;
    logic [1:0]             rdValid;
    logic [1:0]             errValid;
    logic [ADDRS_WIDTH-1:0] addrs [2];
    portState_t             state [2];

`ifdef RSLT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] waitCnt [2];
`endif

    // Index 0 is port A, index 1 is port B, so both ports share one body of logic.
    assign req      = {reqB, reqA};
    assign consume  = {consumeB, consumeA};
    assign addrs[0] = addrsA;
    assign addrs[1] = addrsB;

    // A port is granted in the same cycle it sees its slot valid in the registered
    // scoreboard; a write landing this cycle only becomes visible next cycle, which
    // keeps the buffer's read-after-write ordering without any bypass path.
    always_comb begin
        grant    = '0;
        errPulse = '0;
        for (int p = 0; p < 2; p++) begin
            grant[p] = !RESET && req[p] && slotVld[addrs[p]];
`ifdef RSLT_TIMEOUT_EN
            if (state[p] == ERR) begin
                grant[p]    = 1'b0;
                errPulse[p] = !RESET;
            end
`endif
        end
    end

    // Scoreboard next-state masks: a consuming grant clears its slot, a snooped
    // write sets its slot, and the set is applied last so a fresh result survives
    // a same-cycle consume of the older one.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (wren) begin
            setMask[wraddrs] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            if (grant[p] && consume[p]) begin
                clrMask[addrs[p]] = 1'b1;
            end
        end
    end

    // Unread-result scoreboard, one valid bit per thread slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slotVld <= '0;
        end else begin
            slotVld <= (slotVld & ~clrMask) | setMask;
        end
    end

    // Per-port request FSMs plus the registered data-valid strobes. The read data
    // arrives one cycle after rden, so dvalid is simply rden delayed by one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int p = 0; p < 2; p++) begin
                state[p] <= IDLE;
`ifdef RSLT_TIMEOUT_EN
                waitCnt[p] <= '0;
`endif
            end
            rdValid  <= '0;
            errValid <= '0;
        end else begin
            rdValid  <= grant;
            errValid <= errPulse;
            for (int p = 0; p < 2; p++) begin
                case (state[p])
                    IDLE: begin
                        if (req[p] && !grant[p]) begin
                            state[p] <= WAIT;
`ifdef RSLT_TIMEOUT_EN
                            waitCnt[p] <= '0;
`endif
                        end
                    end
                    WAIT: begin
                        if (!req[p] || grant[p]) begin
                            state[p] <= IDLE;
                        end
`ifdef RSLT_TIMEOUT_EN
                        else if (waitCnt[p] >= TIMEOUT_CNT - CNT_W'(1)) begin
                            state[p]   <= ERR;
                            waitCnt[p] <= TIMEOUT_CNT;
                        end else begin
                            waitCnt[p] <= waitCnt[p] + CNT_W'(1);
                        end
`endif
                    end
`ifdef RSLT_TIMEOUT_EN
                    ERR: begin
                        state[p] <= IDLE;
                    end
`endif
                    default: begin
                        state[p] <= IDLE;
                    end
                endcase
            end
        end
    end

    // Result fields are forced to zero outside a real read so an error response
    // (and idle cycles) present a clean zero value and zero flags.
    assign ackA     = grant[0] | errPulse[0];
    assign rdenA    = grant[0];
    assign rdaddrsA = grant[0] ? addrsA : '0;
    assign dvalidA  = rdValid[0] | errValid[0];
    assign resultA  = rdValid[0] ? rddataA[63:0] : 64'd0;
    assign flagsA   = rdValid[0] ? {rddataA[67:66], rddataA[65:64]} : 4'd0;
    assign errA     = errPulse[0];

    assign ackB     = grant[1] | errPulse[1];
    assign rdenB    = grant[1];
    assign rdaddrsB = grant[1] ? addrsB : '0;
    assign dvalidB  = rdValid[1] | errValid[1];
    assign resultB  = rdValid[1] ? rddataB[63:0] : 64'd0;
    assign flagsB   = rdValid[1] ? {rddataB[67:66], rddataB[65:64]} : 4'd0;
    assign errB     = errPulse[1];

endmodule

// File: tb/tb_logic_rslt_reader.sv
// tb_logic_rslt_reader
// Self-checking bench for logic_rslt_reader (default build, no timeout).
// The bench plays the result buffer itself: it keeps the buffer contents, answers
// the DUT's read strobes one cycle later, and predicts every output from a simple
// slot-valid table plus the word stored at each slot when a grant happens.

module tb_logic_rslt_reader;

    localparam int AW = 4;
    localparam int DW = 68;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          wren;
    logic [AW-1:0] wraddrs;
    logic          reqA, consumeA, reqB, consumeB;
    logic [AW-1:0] addrsA, addrsB;
    logic          ackA, rdenA, dvalidA, errA;
    logic          ackB, rdenB, dvalidB, errB;
    logic [AW-1:0] rdaddrsA, rdaddrsB;
    logic [DW-1:0] rddataA, rddataB;
    logic [63:0]   resultA, resultB;
    logic [3:0]    flagsA, flagsB;

    typedef struct {
        bit          rst;
        bit          we;
        logic [3:0]  wa;
        bit          rqA;
        logic [3:0]  aA;
        bit          cA;
        bit          rqB;
        logic [3:0]  aB;
        bit          cB;
        bit          eAckA;
        bit          eAckB;
        bit          eDvA;
        bit          eDvB;
    } vec_t;

    int            assertions = 0;
    int            failures   = 0;
    int            cycle      = 0;

    logic [DW-1:0] mem [16];
    bit   [15:0]   modelVld;
    bit            prevAckA, prevAckB;
    logic [DW-1:0] prevDataA, prevDataB;
    logic [DW-1:0] rdNextA, rdNextB;
    logic [DW-1:0] wdata;

    logic_rslt_reader dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .wren     (wren),
        .wraddrs  (wraddrs),
        .reqA     (reqA),
        .addrsA   (addrsA),
        .consumeA (consumeA),
        .ackA     (ackA),
        .rdenA    (rdenA),
        .rdaddrsA (rdaddrsA),
        .rddataA  (rddataA),
        .dvalidA  (dvalidA),
        .resultA  (resultA),
        .flagsA   (flagsA),
        .errA     (errA),
        .reqB     (reqB),
        .addrsB   (addrsB),
        .consumeB (consumeB),
        .ackB     (ackB),
        .rdenB    (rdenB),
        .rdaddrsB (rdaddrsB),
        .rddataB  (rddataB),
        .dvalidB  (dvalidB),
        .resultB  (resultB),
        .flagsB   (flagsB),
        .errB     (errB)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] randWord();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    function automatic vec_t row(int rst, int we, int wa, int rqA, int aA, int cA,
                                 int rqB, int aB, int cB,
                                 int eAckA, int eAckB, int eDvA, int eDvB);
        vec_t r;
        r.rst   = (rst != 0);
        r.we    = (we != 0);
        r.wa    = 4'(wa);
        r.rqA   = (rqA != 0);
        r.aA    = 4'(aA);
        r.cA    = (cA != 0);
        r.rqB   = (rqB != 0);
        r.aB    = 4'(aB);
        r.cB    = (cB != 0);
        r.eAckA = (eAckA != 0);
        r.eAckB = (eAckB != 0);
        r.eDvA  = (eDvA != 0);
        r.eDvB  = (eDvB != 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, including the buffer's
    // answer to whatever the DUT read on the previous cycle.
    task automatic applyStimulus(input vec_t v);
        RESET    = v.rst;
        wren     = v.we;
        wraddrs  = v.wa;
        reqA     = v.rqA;
        addrsA   = v.aA;
        consumeA = v.cA;
        reqB     = v.rqB;
        addrsB   = v.aB;
        consumeB = v.cB;
        rddataA  = rdNextA;
        rddataB  = rdNextB;
        wdata    = randWord();
    endtask

    // Compare mid-cycle against the reference prediction, and against the
    // hand-written table expectations when the vector carries them.
    task automatic checkOutput(input vec_t v, input bit useTbl, output bit eAckA, output bit eAckB);
        #4;
        eAckA = !v.rst && v.rqA && modelVld[v.aA];
        eAckB = !v.rst && v.rqB && modelVld[v.aB];
        check("ackA",     64'(ackA),     64'(eAckA));
        check("rdenA",    64'(rdenA),    64'(eAckA));
        check("rdaddrsA", 64'(rdaddrsA), eAckA ? 64'(v.aA) : 64'd0);
        check("dvalidA",  64'(dvalidA),  64'(prevAckA));
        check("resultA",  resultA,       prevAckA ? prevDataA[63:0] : 64'd0);
        check("flagsA",   64'(flagsA),   prevAckA ? 64'(prevDataA[67:64]) : 64'd0);
        check("errA",     64'(errA),     64'd0);
        check("ackB",     64'(ackB),     64'(eAckB));
        check("rdenB",    64'(rdenB),    64'(eAckB));
        check("rdaddrsB", 64'(rdaddrsB), eAckB ? 64'(v.aB) : 64'd0);
        check("dvalidB",  64'(dvalidB),  64'(prevAckB));
        check("resultB",  resultB,       prevAckB ? prevDataB[63:0] : 64'd0);
        check("flagsB",   64'(flagsB),   prevAckB ? 64'(prevDataB[67:64]) : 64'd0);
        check("errB",     64'(errB),     64'd0);
        if (useTbl) begin
            check("tblAckA",    64'(ackA),    64'(v.eAckA));
            check("tblAckB",    64'(ackB),    64'(v.eAckB));
            check("tblDvalidA", 64'(dvalidA), 64'(v.eDvA));
            check("tblDvalidB", 64'(dvalidB), 64'(v.eDvB));
        end
    endtask

    // Step the buffer and the reference across the clock edge. The buffer reads
    // before it writes, so a grant and a write on one slot return the older word.
    task automatic advanceModel(input vec_t v, input bit eAckA, input bit eAckB);
        rdNextA   = (rdenA === 1'b1) ? mem[rdaddrsA] : randWord();
        rdNextB   = (rdenB === 1'b1) ? mem[rdaddrsB] : randWord();
        prevAckA  = eAckA;
        prevAckB  = eAckB;
        prevDataA = mem[v.aA];
        prevDataB = mem[v.aB];
        if (v.rst) begin
            modelVld = '0;
        end else begin
            if (eAckA && v.cA) modelVld[v.aA] = 1'b0;
            if (eAckB && v.cB) modelVld[v.aB] = 1'b0;
            if (v.we)          modelVld[v.wa] = 1'b1;
        end
        if (v.we) mem[v.wa] = wdata;
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    task automatic runVector(input vec_t v, input bit useTbl, output bit eAckA, output bit eAckB);
        applyStimulus(v);
        checkOutput(v, useTbl, eAckA, eAckB);
        advanceModel(v, eAckA, eAckB);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        bit   ea, eb;
        bit   pendA, pendB;
        int   rA, rB, cAr, cBr;

        for (int i = 0; i < 16; i++) mem[i] = randWord();
        modelVld = '0;
        prevAckA = 1'b0;
        prevAckB = 1'b0;
        prevDataA = '0;
        prevDataB = '0;
        rdNextA  = '0;
        rdNextB  = '0;
        RESET    = 1'b1;
        wren     = 1'b0;
        wraddrs  = '0;
        reqA     = 1'b0;
        addrsA   = '0;
        consumeA = 1'b0;
        reqB     = 1'b0;
        addrsB   = '0;
        consumeB = 1'b0;
        rddataA  = '0;
        rddataB  = '0;
        wdata    = '0;
        repeat (2) @(posedge CLK);
        #1;

        //              rst we wa  rqA aA cA  rqB aB cB  ackA ackB dvA dvB
        tbl.push_back(row(1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 1, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 3, 1,  0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0,  1, 3, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 1, 3,  1, 3, 0,  1, 5, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 3, 1,  1, 5, 0,  1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  1, 5, 0,  0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  1, 5, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 1, 5,  0, 0, 0,  1, 5, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  1, 5, 1,  0, 1, 0, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1));
        tbl.push_back(row(0, 1, 7,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 7, 1,  1, 7, 0,  1, 1, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 7, 0,  0, 0, 0,  0, 0, 1, 1));
        tbl.push_back(row(0, 1, 7,  1, 7, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 7, 0,  0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(row(0, 1, 2,  0, 0, 0,  0, 0, 0,  0, 0, 1, 0));
        tbl.push_back(row(0, 1, 2,  1, 2, 1,  0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 2, 1,  0, 0, 0,  1, 0, 1, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0,  1, 9, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(1, 1, 9,  1, 9, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 9, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 9, 0,  1, 7, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 1, 9,  1, 9, 0,  1, 7, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 9, 0,  1, 7, 0,  1, 0, 0, 0));
        tbl.push_back(row(0, 1, 7,  0, 0, 0,  1, 7, 0,  0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  1, 7, 1,  0, 1, 0, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1));
        tbl.push_back(row(0, 1, 4,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 1, 6,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 4, 0,  1, 6, 0,  1, 1, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 6, 0,  1, 4, 0,  1, 1, 1, 1));
        tbl.push_back(row(0, 0, 0,  1, 4, 1,  1, 4, 1,  1, 1, 1, 1));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1, 1));
        tbl.push_back(row(0, 1, 4,  1, 4, 0,  0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  1, 4, 0,  0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 1, 0));

        foreach (tbl[i]) begin
            runVector(tbl[i], 1'b1, ea, eb);
        end

        // Randomised traffic: each requester holds its request until the reference
        // predicts a grant, slots are drawn from a small range so hits and waits
        // both occur, and an occasional reset lands in the middle of it all.
        pendA = 1'b0;
        pendB = 1'b0;
        rA  = 0;
        rB  = 0;
        cAr = 0;
        cBr = 0;
        for (int i = 0; i < 500; i++) begin
            if (!pendA && ($urandom_range(1, 0) == 1)) begin
                pendA = 1'b1;
                rA    = int'($urandom_range(7, 0));
                cAr   = int'($urandom_range(1, 0));
            end
            if (!pendB && ($urandom_range(1, 0) == 1)) begin
                pendB = 1'b1;
                rB    = int'($urandom_range(7, 0));
                cBr   = int'($urandom_range(1, 0));
            end
            v = row(($urandom_range(99, 0) == 0) ? 1 : 0,
                    ($urandom_range(2, 0) == 0) ? 1 : 0,
                    int'($urandom_range(7, 0)),
                    pendA ? 1 : 0, rA, cAr,
                    pendB ? 1 : 0, rB, cBr,
                    0, 0, 0, 0);
            runVector(v, 1'b0, ea, eb);
            if (ea) pendA = 1'b0;
            if (eb) pendB = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
